// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module   : fifo_stream_reader
//  Brief    : Drains a synchronous FIFO with 1-cycle read latency into a
//             2-entry buffer and presents the words on a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_Empty,
  input  logic [DATA_WIDTH-1:0]  fifo_Data,
  output logic                   fifo_Read_Enable,
  output logic [DATA_WIDTH-1:0]  out_Data,
  output logic                   out_Valid,
  input  logic                   out_Ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_Count
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_STOP = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic                   r_in_flight;
  logic [1:0]             r_occ;
  logic [DATA_WIDTH-1:0]  r_head;
  logic [DATA_WIDTH-1:0]  r_tail;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_fire;
  logic [2:0]             w_pending;
  logic                   w_credit_ok;

  assign out_Valid  = (r_occ != 2'd0);
  assign out_Data   = r_head;
  assign word_Count = r_count;
  assign w_fire     = out_Valid & out_Ready;

  // Words already owed to the buffer; a new pop is allowed only if, after this
  // cycle's fire, there is still a free slot waiting for it.
  assign w_pending   = {1'b0, r_occ} + {2'b00, r_in_flight};
  assign w_credit_ok = (w_pending <= (3'd1 + {2'b00, w_fire}));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (enable) w_next_state = c_ST_RUN;
      c_ST_RUN:  if (!enable) w_next_state = c_ST_STOP;
      c_ST_STOP: begin
        if (enable) begin
          w_next_state = c_ST_RUN;
        end else if (!r_in_flight && (r_occ == 2'd0)) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (r_state != c_ST_IDLE);
    fifo_Read_Enable = (r_state == c_ST_RUN) & ~fifo_Empty & w_credit_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_flight <= 1'b0;
      r_occ       <= 2'd0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      r_in_flight <= fifo_Read_Enable;
      case ({r_in_flight, w_fire})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= fifo_Data;
          end else begin
            r_tail <= fifo_Data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Head leaves and the arriving word takes the last occupied slot.
          if (r_occ == 2'd1) begin
            r_head <= fifo_Data;
          end else begin
            r_head <= r_tail;
            r_tail <= fifo_Data;
          end
        end
        default: ;
      endcase
      if (w_fire) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Brief    : Directed bench for fifo_stream_reader with a behavioural FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

  localparam int c_DW = 8;
  localparam int c_CW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            fifo_Empty;
  logic [c_DW-1:0] fifo_Data = '0;
  logic            fifo_Read_Enable;
  logic [c_DW-1:0] out_Data;
  logic            out_Valid;
  logic            out_Ready = 1'b0;
  logic            busy;
  logic [c_CW-1:0] word_Count;

  logic [c_DW-1:0] mem [0:63];
  int              wr_n = 0;
  int              rd_n;
  int              pops;
  int              rx_n;
  int              bad_pop;
  logic            tb_clr = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_stream_reader #(.DATA_WIDTH(c_DW), .COUNT_WIDTH(c_CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .fifo_Empty       (fifo_Empty),
    .fifo_Data        (fifo_Data),
    .fifo_Read_Enable (fifo_Read_Enable),
    .out_Data         (out_Data),
    .out_Valid        (out_Valid),
    .out_Ready        (out_Ready),
    .busy             (busy),
    .word_Count       (word_Count)
  );

  always #5 clock = ~clock;

  assign fifo_Empty = (rd_n >= wr_n);

  // Behavioural FIFO with registered read data plus a delivery monitor.
  always @(posedge clock) begin
    if (tb_clr) begin
      rd_n    <= 0;
      pops    <= 0;
      rx_n    <= 0;
      bad_pop <= 0;
    end else begin
      if (fifo_Read_Enable) begin
        pops <= pops + 1;
        if (rd_n >= wr_n) begin
          bad_pop <= bad_pop + 1;
        end else begin
          fifo_Data <= mem[rd_n];
          rd_n      <= rd_n + 1;
        end
      end
      if (out_Valid && out_Ready) rx_n <= rx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    tb_clr    = 1'b1;
    enable    = 1'b0;
    out_Ready = 1'b0;
    wr_n      = 0;
    tick();
    tick();
    reset  = 1'b1;
    tb_clr = 1'b0;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) mem[wr_n + i] = c_DW'(base + i);
    wr_n = wr_n + n;
  endtask

  initial begin
    int re_cyc, v_cyc, v_n, bad_seq, re_seen, v_seen, found;
    logic [c_DW-1:0] got [0:31];
    int gcyc [0:31];

    // Reset values
    do_reset();
    chk("rst_valid", 32'(out_Valid), 0);
    chk("rst_data", 32'(out_Data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(word_Count), 0);
    chk("rst_rden", 32'(fifo_Read_Enable), 0);

    // Streaming 1..5 at full rate
    load(5, 1);
    out_Ready = 1'b1;
    enable    = 1'b1;
    re_cyc = -1; v_cyc = -1; v_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fifo_Read_Enable && re_cyc < 0) re_cyc = c;
      if (out_Valid && out_Ready && v_n < 32) begin
        if (v_n == 0) v_cyc = c;
        got[v_n]  = out_Data;
        gcyc[v_n] = c;
        v_n++;
      end
    end
    chk("stream_latency", 32'(v_cyc - re_cyc), 2);
    chk("stream_words", 32'(v_n), 5);
    bad_seq = 0;
    for (int k = 0; k < 5 && k < v_n; k++) begin
      if (got[k] != c_DW'(k + 1) || gcyc[k] != v_cyc + k) bad_seq++;
    end
    chk("stream_order", 32'(bad_seq), 0);
    chk("stream_count", 32'(word_Count), 5);
    chk("stream_busy", 32'(busy), 1);
    chk("stream_badpop", 32'(bad_pop), 0);

    // Backpressure with 1..8
    do_reset();
    load(8, 1);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("bp_pops", 32'(pops), 2);
    chk("bp_rden", 32'(fifo_Read_Enable), 0);
    chk("bp_valid", 32'(out_Valid), 1);
    chk("bp_hold", 32'(out_Data), 1);
    out_Ready = 1'b1;
    v_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_Valid && out_Ready && v_n < 32) begin
        got[v_n] = out_Data;
        v_n++;
      end
      tick();
    end
    chk("bp_words", 32'(v_n), 8);
    bad_seq = 0;
    for (int k = 0; k < 8 && k < v_n; k++) if (got[k] != c_DW'(k + 1)) bad_seq++;
    chk("bp_order", 32'(bad_seq), 0);
    chk("bp_count", 32'(word_Count), 8);
    chk("bp_rx", 32'(rx_n), 8);

    // Asynchronous reset while a word is on offer
    out_Ready = 1'b0;
    load(3, 9);
    for (int c = 0; c < 5; c++) tick();
    chk("ar_pre_valid", 32'(out_Valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_Valid), 0);
    chk("ar_data", 32'(out_Data), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_count", 32'(word_Count), 0);
    chk("ar_rden", 32'(fifo_Read_Enable), 0);

    // Empty FIFO
    do_reset();
    enable = 1'b1;
    re_seen = 0; v_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fifo_Read_Enable) re_seen++;
      if (out_Valid) v_seen++;
    end
    chk("empty_rden", 32'(re_seen), 0);
    chk("empty_valid", 32'(v_seen), 0);
    chk("empty_busy", 32'(busy), 1);

    // Stop right after a pop with the pipeline loaded
    do_reset();
    load(10, 1);
    out_Ready = 1'b1;
    enable    = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (out_Valid && fifo_Read_Enable) found = 1;
    end
    chk("stop_sync", 32'(found), 1);
    enable = 1'b0;
    v_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_Valid && out_Ready && v_n < 32) begin
        got[v_n] = out_Data;
        v_n++;
      end
      tick();
    end
    chk("stop_words", 32'(v_n), 3);
    bad_seq = 0;
    for (int k = 0; k < 3 && k < v_n; k++) if (got[k] != c_DW'(k + 1)) bad_seq++;
    chk("stop_order", 32'(bad_seq), 0);
    chk("stop_pops", 32'(pops), 3);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_count", 32'(word_Count), 3);

    // Counter wrap with a 4-bit counter
    do_reset();
    load(17, 0);
    out_Ready = 1'b1;
    enable    = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    chk("wrap_rx", 32'(rx_n), 17);
    chk("wrap_count", 32'(word_Count), 1);
    chk("wrap_badpop", 32'(bad_pop), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
